sync_fifo_flex: RTL and testbench
=================================

# sync_fifo_flex

Single-clock, parametrised FIFO for same-domain buffering, the companion to the dual-clock FIFO.
- Sizing: arbitrary (non-power-of-two) depth.
- Read modes: selectable first-word-fall-through (FWFT) or registered-read.
- Status: occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags.
- Control: synchronous flush.

## Interface
- DATA_WIDTH, 8, word width (>=1)
- DEPTH, 6, storage entries (>=2, need not be a power of two)
- FWFT, 1, 1 = first-word-fall-through read; 0 = registered read with rvalid
- AF_THRESH, DEPTH-1, almost_full asserted when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
- CW, $clog2(DEPTH+1), count width (derived, not overridden)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous clear of contents
- wen  in  1  write request
- wdata  in  DATA_WIDTH  write data
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AF_THRESH
- ren  in  1  read request (FWFT: pop/acknowledge head)
- rdata  out  DATA_WIDTH  read data
- rvalid  out  1  FWFT=0 only: rdata valid this cycle; tied to ~empty when FWFT=1
- empty  out  1  count == 0
- almost_empty  out  1  count <= AE_THRESH
- count  out  CW  current occupancy 0..DEPTH
- overflow  out  1  sticky: wen seen while full
- underflow  out  1  sticky: ren seen while empty
- clear_err  in  1  clears overflow/underflow

## Operation
- Accept conditions:
  - wacc = wen & ~full & ~flush
  - racc = ren & ~empty & ~flush
  - Both accept conditions are evaluated on registered flags, so a write into a full FIFO is rejected even with a simultaneous accepted read.
- Pointers: wptr/rptr in 0..DEPTH-1, increment on wacc/racc, wrap DEPTH-1 -> 0 (explicit compare, not modulo 2^n).
- count: next = count + wacc - racc. wacc & racc leaves count unchanged.
- Flags are pure decodes of registered count (glitch-free, no extra latency).
- Memory: written at wptr on wacc, combinational read at rptr.
- FWFT=1:
  - rdata = mem[rptr] whenever ~empty.
  - racc advances rptr, and the next word appears in the following cycle.
- FWFT=0:
  - On racc, rdata <= mem[rptr] and rvalid <= 1. Otherwise rvalid <= 0 and rdata holds its last value.
- Error flags:
  - Set condition: overflow set on wen & full; underflow set on ren & empty (flush cycles excluded).
  - clear_err clears both flags, but a set in the same cycle wins.
- flush:
  - Next cycle: wptr = rptr = 0, count = 0, rvalid = 0.
  - Memory contents and error flags are untouched.
  - A wen/ren in the flush cycle is discarded and does not set error flags.

## Timing
- Reset (async assert, sync-safe deassert expected externally): count=0, empty=1, almost_empty=1, full=0, almost_full=0, rvalid=0, rdata=0, overflow=0, underflow=0, pointers=0.
- Reset mid-operation: all state returns to the reset values immediately; contents are lost logically.
- Write-to-read latency:
  - FWFT=1: word written at edge N, empty=0 and rdata valid after edge N, available to pop from cycle N+1.
  - FWFT=0: earliest ren accepted in cycle N+1, rvalid/rdata in cycle N+2.
- Read latency, FWFT=0: 1 cycle from accepted ren to rvalid.
- Full to not-full: the cycle after the racc edge.
- Sustained throughput: one write and one read per cycle at any occupancy 1..DEPTH-1.
- Flag timing: almost_full/almost_empty update on the same edge as count.

## Test plan
- Reset then fill (DEPTH=6, wdata 0x10..0x15, no ren):
  - Count steps 1..6.
  - almost_full rises when count reaches 5; full=1 at 6.
  - A 7th wen (0x16) is rejected and sets overflow=1; count stays 6.
- Drain (FWFT=1): ren held 6 cycles -> rdata 0x10..0x15 in order, empty=1 after the last; an extra ren sets underflow=1.
- Drain (FWFT=0): ren each cycle -> rvalid pulses the cycle after each accept, rdata 0x10..0x15; rdata holds 0x15 afterwards.
- Concurrent stream at count=3 with wen&ren 20 cycles: count stays 3, pointers wrap 5->0 without data loss, and the output sequence matches the input order.
- flush at count=4 with simultaneous wen=1 -> next cycle count=0, empty=1, no overflow; clear_err with overflow set -> 0 next cycle; clear_err with simultaneous wen&full -> overflow stays 1.
- Async reset asserted mid-stream (count=2, FWFT=0, rvalid=1) -> all outputs take their reset values without waiting for a clock edge; normal operation resumes after deassert.

Source files
------------

// File: rtl/sync_fifo_flex_if.sv
// Handshake bundle for sync_fifo_flex: write port, read port, status and error control.
// The FIFO takes the slave side; the producer/consumer logic takes the master side.
interface sync_fifo_flex_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 6
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  flush;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  full;
    logic                  almost_full;
    logic                  ren;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  empty;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;
    logic                  clear_err;

    modport slave (
        input  flush, wen, wdata, ren, clear_err,
        output full, almost_full, rdata, rvalid, empty, almost_empty,
               count, overflow, underflow
    );

    modport master (
        output flush, wen, wdata, ren, clear_err,
        input  full, almost_full, rdata, rvalid, empty, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO of arbitrary depth with FWFT or registered read, occupancy
// count, almost-full/almost-empty thresholds, sticky error flags and flush.
module sync_fifo_flex #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 6,
    parameter bit FWFT       = 1'b1,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input logic             clk,
    input logic             reset,
    sync_fifo_flex_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  empty, full, wacc, racc;

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned (which would infer a latch); blocking '=' is used here.
    always_comb begin
        empty       = (count_q == '0);
        full        = (count_q == CW'(DEPTH));
        wacc        = bus.wen & ~full  & ~bus.flush;
        racc        = bus.ren & ~empty & ~bus.flush;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;

        if (bus.flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // Explicit wrap so any DEPTH works, not just powers of two.
            if (wacc) wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
            if (racc) rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
            unique case ({wacc, racc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // A new error event outranks clear_err in the same cycle.
        overflow_d  = (bus.wen & full  & ~bus.flush) ? 1'b1 :
                      bus.clear_err ? 1'b0 : overflow_q;
        underflow_d = (bus.ren & empty & ~bus.flush) ? 1'b1 :
                      bus.clear_err ? 1'b0 : underflow_q;
    end

    // NOTE: sequential state is updated with non-blocking '<=' so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: storage has no reset; stale words are unreachable because count
    // and the pointers are reset, and a reset-free array maps onto RAM cells.
    always_ff @(posedge clk) begin
        if (wacc) mem_q[wptr_q] <= bus.wdata;
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is presented directly; forced to zero while empty so
            // the output never shows uninitialised storage.
            assign bus.rdata  = empty ? '0 : mem_q[rptr_q];
            assign bus.rvalid = ~empty;
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
            logic                  rvalid_q, rvalid_d;

            always_comb begin
                rvalid_d = racc;
                rdata_d  = racc ? mem_q[rptr_q] : rdata_q;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= rvalid_d;
                end
            end

            assign bus.rdata  = rdata_q;
            assign bus.rvalid = rvalid_q;
        end
    endgenerate

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
    assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: an FWFT instance and a registered-read instance share
// one stimulus stream and are checked against a queue-based reference model.
module tb_sync_fifo_flex;
    localparam int DW    = 8;
    localparam int DEPTH = 6;
    localparam int AF    = DEPTH - 1;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          wen, ren, flush, clear_err;
    logic [DW-1:0] wdata;

    int tests = 0;
    int fails = 0;

    // Reference model: queue of stored words plus the sticky flags and the
    // registered-read output register.
    logic [DW-1:0] mq [$];
    bit            m_ovf, m_unf, m_rv0;
    logic [DW-1:0] m_rd0;

    sync_fifo_flex_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) b1 ();
    sync_fifo_flex_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) b0 ();

    assign b1.wen = wen;  assign b1.wdata = wdata;  assign b1.ren = ren;
    assign b1.flush = flush;  assign b1.clear_err = clear_err;
    assign b0.wen = wen;  assign b0.wdata = wdata;  assign b0.ren = ren;
    assign b0.flush = flush;  assign b0.clear_err = clear_err;

    sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(b1)
    );
    sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(b0)
    );

    always #5 clk = ~clk;

    // Status vector: {count, empty, almost_empty, almost_full, full, overflow, underflow}
    function automatic logic [8:0] exp_st();
        int n;
        n = mq.size();
        return {3'(n), n == 0, n <= AE, n >= AF, n == DEPTH, m_ovf, m_unf};
    endfunction

    function automatic logic [8:0] st1();
        return {b1.count, b1.empty, b1.almost_empty, b1.almost_full, b1.full,
                b1.overflow, b1.underflow};
    endfunction

    function automatic logic [8:0] st0();
        return {b0.count, b0.empty, b0.almost_empty, b0.almost_full, b0.full,
                b0.overflow, b0.underflow};
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rv0 = 1'b0;
        m_rd0 = '0;
    endfunction

    // One clock: drive inputs at the negedge, advance the model across the
    // posedge, return at the next negedge with DUT outputs settled.
    task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r,
                         input bit f, input bit c);
        bit is_full, is_empty, wacc, racc, set_o, set_u;
        wen = w;  wdata = d;  ren = r;  flush = f;  clear_err = c;
        is_full  = (mq.size() == DEPTH);
        is_empty = (mq.size() == 0);
        wacc  = w && !is_full  && !f;
        racc  = r && !is_empty && !f;
        set_o = w && is_full  && !f;
        set_u = r && is_empty && !f;
        @(posedge clk);
        if (f) begin
            mq.delete();
            m_rv0 = 1'b0;
        end else begin
            m_rv0 = racc;
            if (racc) m_rd0 = mq.pop_front();
            if (wacc) mq.push_back(d);
        end
        m_ovf = set_o ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_unf = set_u ? 1'b1 : (c ? 1'b0 : m_unf);
        @(negedge clk);
        wen = 1'b0;  ren = 1'b0;  flush = 1'b0;  clear_err = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;  wen = 0;  ren = 0;  flush = 0;  clear_err = 0;  wdata = '0;
        model_reset();
        #12;
        tests++;
        if (st1() !== 9'b000_1_1_0_0_0_0) begin
            fails++;  $display("FAIL reset_status_fwft: got %b expected %b", st1(), 9'b000110000);
        end
        tests++;
        if (st0() !== 9'b000_1_1_0_0_0_0) begin
            fails++;  $display("FAIL reset_status_reg: got %b expected %b", st0(), 9'b000110000);
        end
        tests++;
        if ({b0.rvalid, b0.rdata, b1.rvalid, b1.rdata} !== '0) begin
            fails++;  $display("FAIL reset_read_port: got %h expected 0",
                               {b0.rvalid, b0.rdata, b1.rvalid, b1.rdata});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, DW'(8'h10 + i), 1'b0, 1'b0, 1'b0);
            tests++;
            if (st1() !== {3'(i + 1), 1'b0, (i + 1) <= AE, (i + 1) >= 5, (i + 1) == 6, 2'b00}) begin
                fails++;  $display("FAIL fill_status_%0d: got %b expected %b", i, st1(), exp_st());
            end
            tests++;
            if (st0() !== exp_st()) begin
                fails++;  $display("FAIL fill_status_reg_%0d: got %b expected %b", i, st0(), exp_st());
            end
        end
        tests++;
        if (b1.rdata !== 8'h10 || b0.rvalid !== 1'b0) begin
            fails++;  $display("FAIL fill_head: got rdata=%h rvalid0=%b expected 10/0", b1.rdata, b0.rvalid);
        end
        cycle(1'b1, 8'h16, 1'b0, 1'b0, 1'b0);
        tests++;
        if (st1() !== 9'b110_0_0_1_1_1_0 || st0() !== 9'b110_0_0_1_1_1_0) begin
            fails++;  $display("FAIL fill_overflow: got %b/%b expected %b", st1(), st0(), 9'b110001110);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            tests++;
            if (b1.rdata !== DW'(8'h10 + i)) begin
                fails++;  $display("FAIL drain_fwft_%0d: got %h expected %h", i, b1.rdata, 8'h10 + i);
            end
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
            tests++;
            if (b0.rvalid !== 1'b1 || b0.rdata !== DW'(8'h10 + i)) begin
                fails++;  $display("FAIL drain_reg_%0d: got rvalid=%b rdata=%h expected 1/%h",
                                   i, b0.rvalid, b0.rdata, 8'h10 + i);
            end
        end
        tests++;
        if (b1.empty !== 1'b1 || b1.count !== 3'd0 || b1.rvalid !== 1'b0) begin
            fails++;  $display("FAIL drain_empty: got empty=%b count=%0d expected 1/0", b1.empty, b1.count);
        end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tests++;
        if (st1() !== 9'b000_1_1_0_0_1_1 || st0() !== 9'b000_1_1_0_0_1_1) begin
            fails++;  $display("FAIL drain_underflow: got %b/%b expected %b", st1(), st0(), 9'b000110011);
        end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (b0.rvalid !== 1'b0 || b0.rdata !== 8'h15) begin
            fails++;  $display("FAIL drain_hold: got rvalid=%b rdata=%h expected 0/15", b0.rvalid, b0.rdata);
        end
    endtask

    task automatic test_clear();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tests++;
        if ({b1.overflow, b1.underflow, b0.overflow, b0.underflow} !== 4'b0000) begin
            fails++;  $display("FAIL clear_err: got %b expected 0000",
                               {b1.overflow, b1.underflow, b0.overflow, b0.underflow});
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] head;
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            head = (i < 3) ? DW'(8'hA0 + i) : DW'(8'hB0 + i - 3);
            tests++;
            if (b1.rdata !== head) begin
                fails++;  $display("FAIL stream_fwft_%0d: got %h expected %h", i, b1.rdata, head);
            end
            cycle(1'b1, DW'(8'hB0 + i), 1'b1, 1'b0, 1'b0);
            tests++;
            if (b1.count !== 3'd3 || b0.count !== 3'd3 || b0.rvalid !== 1'b1 || b0.rdata !== head) begin
                fails++;  $display("FAIL stream_reg_%0d: got count=%0d rvalid=%b rdata=%h expected 3/1/%h",
                                   i, b0.count, b0.rvalid, b0.rdata, head);
            end
        end
    endtask

    task automatic test_flush();
        cycle(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        tests++;
        if (b1.count !== 3'd4) begin
            fails++;  $display("FAIL flush_pre: got count=%0d expected 4", b1.count);
        end
        cycle(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        tests++;
        if (st1() !== 9'b000_1_1_0_0_0_0 || st0() !== 9'b000_1_1_0_0_0_0 || b0.rvalid !== 1'b0) begin
            fails++;  $display("FAIL flush_count4: got %b/%b rvalid=%b expected %b/0",
                               st1(), st0(), b0.rvalid, 9'b000110000);
        end
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
        tests++;
        if (st1() !== 9'b000_1_1_0_0_0_0 || st0() !== exp_st()) begin
            fails++;  $display("FAIL flush_full_no_ovf: got %b expected %b", st1(), 9'b000110000);
        end
        cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        tests++;
        if (b1.rdata !== 8'h5A || b1.count !== 3'd1) begin
            fails++;  $display("FAIL flush_resume: got rdata=%h count=%0d expected 5a/1", b1.rdata, b1.count);
        end
    endtask

    task automatic test_error_flags();
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, DW'(8'h70 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h7F, 1'b0, 1'b0, 1'b0);
        tests++;
        if (b1.overflow !== 1'b1 || b0.overflow !== 1'b1 || b1.count !== 3'd6) begin
            fails++;  $display("FAIL err_set: got ovf=%b count=%0d expected 1/6", b1.overflow, b1.count);
        end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (b1.overflow !== 1'b0 || b0.overflow !== 1'b0) begin
            fails++;  $display("FAIL err_clear: got ovf=%b/%b expected 0", b1.overflow, b0.overflow);
        end
        cycle(1'b1, 8'h7E, 1'b0, 1'b0, 1'b1);
        tests++;
        if (b1.overflow !== 1'b1 || b0.overflow !== 1'b1) begin
            fails++;  $display("FAIL err_set_wins: got ovf=%b/%b expected 1", b1.overflow, b0.overflow);
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tests++;
        if (b0.count !== 3'd2 || b0.rvalid !== 1'b1 || b0.rdata !== 8'h30) begin
            fails++;  $display("FAIL areset_pre: got count=%0d rvalid=%b rdata=%h expected 2/1/30",
                               b0.count, b0.rvalid, b0.rdata);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if (st1() !== 9'b000_1_1_0_0_0_0 || st0() !== 9'b000_1_1_0_0_0_0 ||
            {b0.rvalid, b0.rdata, b1.rvalid, b1.rdata} !== '0) begin
            fails++;  $display("FAIL areset_immediate: got %b/%b rvalid0=%b rdata0=%h expected reset values",
                               st1(), st0(), b0.rvalid, b0.rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tests++;
        if (b0.rvalid !== 1'b1 || b0.rdata !== 8'h77 || st1() !== exp_st()) begin
            fails++;  $display("FAIL areset_resume: got rvalid=%b rdata=%h expected 1/77", b0.rvalid, b0.rdata);
        end
    endtask

    task automatic test_random();
        bit w, r, f, c;
        int pw;
        for (int k = 0; k < 400; k++) begin
            pw = ((k / 40) % 2 == 0) ? 75 : 30;
            w  = ($urandom_range(0, 99) < pw);
            r  = ($urandom_range(0, 99) < (100 - pw));
            f  = ($urandom_range(0, 99) < 3);
            c  = !f && ($urandom_range(0, 99) < 6);
            if (mq.size() != 0) begin
                tests++;
                if (b1.rdata !== mq[0]) begin
                    fails++;  $display("FAIL rand_fwft_head_%0d: got %h expected %h", k, b1.rdata, mq[0]);
                end
            end
            cycle(w, DW'($urandom), r, f, c);
            tests++;
            if (st1() !== exp_st() || st0() !== exp_st() || b1.rvalid !== (mq.size() != 0)) begin
                fails++;  $display("FAIL rand_status_%0d: got %b/%b expected %b", k, st1(), st0(), exp_st());
            end
            tests++;
            if (b0.rvalid !== m_rv0 || b0.rdata !== m_rd0) begin
                fails++;  $display("FAIL rand_reg_read_%0d: got rvalid=%b rdata=%h expected %b/%h",
                                   k, b0.rvalid, b0.rdata, m_rv0, m_rd0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_clear();
        test_back_to_back();
        test_flush();
        test_error_flags();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
